dmux_8way: RTL and testbench
============================

DMUX_8WAY -- requirements
Module: dmux_8way

Interface
REQ-001 Parameter WIDTH, default 1: bit width of the data input and of each of the eight data outputs.
REQ-002 Parameter REGISTERED, default 0: 0 gives combinational outputs; 1 gives outputs registered on clk.
REQ-003 Port clk, input, 1: rising-edge clock; used only when REGISTERED=1.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port in, input, WIDTH: data to be routed.
REQ-006 Port sel, input, 3: destination select; 0 selects a, 7 selects h.
REQ-007 Ports a, b, c, d, e, f, g, h, output, WIDTH each: demultiplexed destinations.
REQ-008 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-009 Port order SHALL be clk, rst_n, in, sel, a, b, c, d, e, f, g, h.

Function
REQ-010 The output indexed by sel (a=000, b=001, c=010, d=011, e=100, f=101, g=110, h=111) SHALL equal in.
REQ-011 All seven non-selected outputs SHALL be all-zeros.
REQ-012 With in all-zeros, all eight outputs SHALL be zero regardless of sel.
REQ-013 At most one output SHALL be non-zero at any time.
REQ-014 With REGISTERED=0, outputs SHALL follow in and sel combinationally with zero-cycle latency and no clk dependency while rst_n=1.
REQ-015 With REGISTERED=1, outputs SHALL reflect the in and sel values sampled at the previous rising clk edge, giving one-cycle latency.
REQ-016 With REGISTERED=1, a change in sel or in between edges SHALL NOT affect the outputs until the next rising edge.
REQ-017 With REGISTERED=1, consecutive sel changes on consecutive edges SHALL each appear for exactly one cycle, with no skipped or merged values.
REQ-018 For any WIDTH, bits SHALL be routed unchanged, with no truncation, sign handling or reordering.
REQ-019 sel is always driven to 0 or 1; X or Z behaviour is not specified.

Reset
REQ-020 While rst_n=0, all outputs a through h SHALL be zero in both modes, asynchronously and without waiting for clk.
REQ-021 With REGISTERED=1, the output registers SHALL clear asynchronously on the falling edge of rst_n.
REQ-022 With REGISTERED=1, after rst_n rises, outputs SHALL stay zero until the first rising clk edge, then show the values sampled at that edge.
REQ-023 With REGISTERED=0, outputs SHALL resume combinational behaviour immediately when rst_n rises.
REQ-024 If rst_n is asserted mid-operation, the design SHALL discard the pending routed value; no stale value reappears after release.

Structure
REQ-025 A shared package SHALL hold the sel encoding constants SEL_A through SEL_H (0..7) and the output-count constant NUM_OUT=8.
REQ-026 The design SHALL contain one natural sub-module, dmux, a 1-to-2 WIDTH-bit demultiplexer.
REQ-027 dmux_8way SHALL be built as a three-level tree of seven dmux instances, with sel[2] at the root and sel[0] at the leaves.
REQ-028 The optional register stage SHALL sit after the tree, generated on REGISTERED, with one WIDTH-bit register per output.
REQ-029 The design SHALL contain no latches.

Verification
REQ-030 Walk test: REGISTERED=0, WIDTH=1, rst_n=1, in=1, sel stepped 000 to 111 every 10 ns -> {a..h} = 10000000, 01000000, ..., 00000001 in turn.
REQ-031 Zero input: in=0, sel=100 -> {a..h} = 00000000.
REQ-032 Async reset: REGISTERED=1, in=1, sel=011 held with d=1; drop rst_n mid-cycle -> all outputs 0 immediately.
REQ-033 Reset release: after REQ-032, raise rst_n -> outputs stay 0 until the next rising edge, then d=1.
REQ-034 Latency: REGISTERED=1, in=1, sel changes 000->101 just after an edge -> a stays 1 until the next edge, then f=1 and a=0.
REQ-035 Width: WIDTH=16, in=16'hA5C3, sel=110 -> g=16'hA5C3, all others 16'h0000; each sel value checked the same way.

Source files
------------

// File: rtl/dmux_8way_pkg.sv
// Shared constants for the 8-way demultiplexer: select encodings and output count.
package dmux_8way_pkg;

    // Number of demultiplexed destinations
    localparam int NUM_OUT = 8;

    // Select encodings, one per destination (a..h)
    localparam logic [2:0] SEL_A = 3'd0;
    localparam logic [2:0] SEL_B = 3'd1;
    localparam logic [2:0] SEL_C = 3'd2;
    localparam logic [2:0] SEL_D = 3'd3;
    localparam logic [2:0] SEL_E = 3'd4;
    localparam logic [2:0] SEL_F = 3'd5;
    localparam logic [2:0] SEL_G = 3'd6;
    localparam logic [2:0] SEL_H = 3'd7;

endpackage : dmux_8way_pkg

// File: rtl/dmux_8way_dmux.sv
// 1-to-2 demultiplexer: routes in to a when sel=0, to b when sel=1; the other side is zero.
module dmux #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] in,
    input  logic             sel,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b
);

    // Steer the input to one side, hold the other at zero
    always_comb begin
        a = '0;
        b = '0;
        if (sel) begin
            b = in;
        end else begin
            a = in;
        end
    end

endmodule : dmux

// File: rtl/dmux_8way.sv
// 8-way demultiplexer built as a three-level tree of 1-to-2 dmux cells
// (sel[2] at the root, sel[0] at the leaves), with an optional output
// register stage. Outputs are forced to zero while rst_n is low.
module dmux_8way
    import dmux_8way_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter bit REGISTERED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] h
);

    // Tree nodes: lvl1 split on sel[2], lvl2 on sel[1], leaf on sel[0].
    // leaf[i] is the destination whose encoding equals i.
    logic [WIDTH-1:0] lvl1 [2];
    logic [WIDTH-1:0] lvl2 [4];
    logic [WIDTH-1:0] leaf [NUM_OUT];
    logic [WIDTH-1:0] out_o [NUM_OUT];

    dmux #(.WIDTH(WIDTH)) u_root (
        .in  (in),
        .sel (sel[2]),
        .a   (lvl1[0]),
        .b   (lvl1[1])
    );

    for (genvar i = 0; i < 2; i++) begin : g_mid
        dmux #(.WIDTH(WIDTH)) u_mid (
            .in  (lvl1[i]),
            .sel (sel[1]),
            .a   (lvl2[2*i]),
            .b   (lvl2[2*i+1])
        );
    end

    for (genvar i = 0; i < 4; i++) begin : g_leaf
        dmux #(.WIDTH(WIDTH)) u_leaf (
            .in  (lvl2[i]),
            .sel (sel[0]),
            .a   (leaf[2*i]),
            .b   (leaf[2*i+1])
        );
    end

    if (REGISTERED) begin : g_reg
        logic [WIDTH-1:0] out_d [NUM_OUT];
        logic [WIDTH-1:0] out_q [NUM_OUT];

        // Next-state for the output registers is the tree result
        always_comb begin
            for (int i = 0; i < NUM_OUT; i++) begin
                out_d[i] = leaf[i];
            end
        end

        // One register per output; async clear drops any pending routed value
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < NUM_OUT; i++) begin
                    out_q[i] <= '0;
                end
            end else begin
                for (int i = 0; i < NUM_OUT; i++) begin
                    out_q[i] <= out_d[i];
                end
            end
        end

        // Registered outputs drive the ports directly
        always_comb begin
            for (int i = 0; i < NUM_OUT; i++) begin
                out_o[i] = out_q[i];
            end
        end
    end else begin : g_comb
        // Clock has no role in the combinational build
        logic clk_unused;
        assign clk_unused = clk;

        // Combinational path, gated to zero while reset is held
        always_comb begin
            for (int i = 0; i < NUM_OUT; i++) begin
                out_o[i] = rst_n ? leaf[i] : '0;
            end
        end
    end

    assign a = out_o[SEL_A];
    assign b = out_o[SEL_B];
    assign c = out_o[SEL_C];
    assign d = out_o[SEL_D];
    assign e = out_o[SEL_E];
    assign f = out_o[SEL_F];
    assign g = out_o[SEL_G];
    assign h = out_o[SEL_H];

endmodule : dmux_8way

// File: tb/tb_dmux_8way.sv
// Directed testbench for dmux_8way: combinational and registered builds at
// WIDTH=1 and WIDTH=16, checked against hand-computed one-hot patterns.
module tb_dmux_8way;

    logic        clk;
    logic        rst_n;
    logic        in1;
    logic [15:0] in16;
    logic [2:0]  sel;

    logic        c1  [8];
    logic        r1  [8];
    logic [15:0] c16 [8];
    logic [15:0] r16 [8];

    int n_checks = 0;
    int n_errors = 0;

    dmux_8way #(.WIDTH(1), .REGISTERED(1'b0)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in(in1), .sel(sel),
        .a(c1[0]), .b(c1[1]), .c(c1[2]), .d(c1[3]),
        .e(c1[4]), .f(c1[5]), .g(c1[6]), .h(c1[7])
    );

    dmux_8way #(.WIDTH(1), .REGISTERED(1'b1)) u_r1 (
        .clk(clk), .rst_n(rst_n), .in(in1), .sel(sel),
        .a(r1[0]), .b(r1[1]), .c(r1[2]), .d(r1[3]),
        .e(r1[4]), .f(r1[5]), .g(r1[6]), .h(r1[7])
    );

    dmux_8way #(.WIDTH(16), .REGISTERED(1'b0)) u_c16 (
        .clk(clk), .rst_n(rst_n), .in(in16), .sel(sel),
        .a(c16[0]), .b(c16[1]), .c(c16[2]), .d(c16[3]),
        .e(c16[4]), .f(c16[5]), .g(c16[6]), .h(c16[7])
    );

    dmux_8way #(.WIDTH(16), .REGISTERED(1'b1)) u_r16 (
        .clk(clk), .rst_n(rst_n), .in(in16), .sel(sel),
        .a(r16[0]), .b(r16[1]), .c(r16[2]), .d(r16[3]),
        .e(r16[4]), .f(r16[5]), .g(r16[6]), .h(r16[7])
    );

    // {a..h} with a as the MSB
    wire [7:0] c1_v = {c1[0], c1[1], c1[2], c1[3], c1[4], c1[5], c1[6], c1[7]};
    wire [7:0] r1_v = {r1[0], r1[1], r1[2], r1[3], r1[4], r1[5], r1[6], r1[7]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in1   = 1'b0;
        in16  = 16'h0000;
        sel   = 3'd0;

        // Reset holds every output at zero in both modes
        #2;
        in1  = 1'b1;
        in16 = 16'hA5C3;
        sel  = 3'd3;
        #1;
        check("rst_comb_w1", {8'h00, c1_v}, 16'h0000);
        check("rst_reg_w1", {8'h00, r1_v}, 16'h0000);
        check("rst_comb_w16_d", c16[3], 16'h0000);
        after_edge();
        check("rst_reg_edge_w1", {8'h00, r1_v}, 16'h0000);
        check("rst_reg_edge_w16_d", r16[3], 16'h0000);

        // Release mid-cycle: comb resumes at once, registered waits for an edge
        #2;
        rst_n = 1'b1;
        #1;
        check("comb_resume", {8'h00, c1_v}, 16'h0010);
        check("reg_rel_hold", {8'h00, r1_v}, 16'h0000);
        after_edge();
        check("reg_load_d", {8'h00, r1_v}, 16'h0010);
        check("reg_load_w16_d", r16[3], 16'hA5C3);

        // Async clear mid-cycle, then release and wait for the next edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clr_reg", {8'h00, r1_v}, 16'h0000);
        check("async_clr_comb", {8'h00, c1_v}, 16'h0000);
        #2;
        rst_n = 1'b1;
        #1;
        check("rel_wait", {8'h00, r1_v}, 16'h0000);
        after_edge();
        check("rel_first_edge", {8'h00, r1_v}, 16'h0010);

        // Captured value is discarded by reset and must not reappear
        sel = 3'd2;
        after_edge();
        check("stale_pre", {8'h00, r1_v}, 16'h0020);
        in1 = 1'b0;
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #1;
        check("stale_rel", {8'h00, r1_v}, 16'h0000);
        after_edge();
        check("stale_edge", {8'h00, r1_v}, 16'h0000);

        // One-cycle latency: a sel change just after an edge waits for the next
        in1 = 1'b1;
        sel = 3'd0;
        after_edge();
        check("lat_a", {8'h00, r1_v}, 16'h0080);
        sel = 3'd5;
        #3;
        check("lat_hold_a", {8'h00, r1_v}, 16'h0080);
        check("lat_comb_f", {8'h00, c1_v}, 16'h0004);
        after_edge();
        check("lat_f", {8'h00, r1_v}, 16'h0004);

        // Consecutive sel values on consecutive edges, one cycle each
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            after_edge();
            check($sformatf("seq_reg_%0d", i), {8'h00, r1_v}, {8'h00, 8'h80 >> i});
        end

        // Walk test on the combinational build, 10 ns per step
        in1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            #10;
            check($sformatf("walk_%0d", i), {8'h00, c1_v}, {8'h00, 8'h80 >> i});
        end

        // Zero input gives all-zero outputs
        in1 = 1'b0;
        sel = 3'd4;
        #1;
        check("zero_comb", {8'h00, c1_v}, 16'h0000);
        after_edge();
        check("zero_reg", {8'h00, r1_v}, 16'h0000);

        // Wide data routed unchanged for every sel; others stay zero
        in16 = 16'hA5C3;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            #1;
            for (int j = 0; j < 8; j++) begin
                check($sformatf("w16_s%0d_o%0d", s, j), c16[j], (j == s) ? 16'hA5C3 : 16'h0000);
            end
        end
        in16 = 16'h8001;
        sel  = 3'd1;
        #1;
        check("w16_8001_b", c16[1], 16'h8001);
        check("w16_8001_a", c16[0], 16'h0000);

        // Wide registered path, g selected
        in16 = 16'hA5C3;
        sel  = 3'd6;
        after_edge();
        for (int j = 0; j < 8; j++) begin
            check($sformatf("r16_g_o%0d", j), r16[j], (j == 6) ? 16'hA5C3 : 16'h0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dmux_8way
